key_debounce_sched: RTL and testbench

- Time-shares a single debounce counter across four active-low push-buttons. Keys idle high, pressed = 0.
- A round-robin scheduler grants the counter to one key whose synchronized level differs from its debounced level.
- The granted key's new level is confirmed after CNTMAX+1 stable cycles.
- On confirmation the block emits one-cycle press/release pulses and toggles a per-key LED. It sits between the raw key pins and the LED/user logic.

---
 rtl/key_debounce_sched.sv | 148 ++++++++++++++
 tb/tb_key_debounce_sched.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_sched.sv
// rtl/key_debounce_sched.sv - four-key debouncer sharing one round-robin-scheduled filter counter
//
// Purpose: synchronizes four active-low keys and confirms each level change
// with a single shared counter that is handed to one pending key at a time.
// Confirmed changes update key_state, pulse key_press/key_release for one
// cycle and toggle the key's LED on presses.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   keyin[3:0]   raw key levels, active-low, asynchronous to clk
//   key_state    debounced levels (1 = released)
//   key_press    one-cycle pulse on a confirmed 1->0
//   key_release  one-cycle pulse on a confirmed 0->1
//   led          toggles on each confirmed press of the matching key
//   busy         counter currently granted to a key
//   grant_id     key holding the counter (meaningful only while busy)

module key_debounce_sched #(
    parameter int          CNTW   = 20,
    parameter int unsigned CNTMAX = 999_999
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] keyin,
    output logic [3:0] key_state,
    output logic [3:0] key_press,
    output logic [3:0] key_release,
    output logic [3:0] led,
    output logic       busy,
    output logic [1:0] grant_id
);

    localparam logic [CNTW-1:0] CNT_TERM = CNTW'(CNTMAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILTER = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t          state_q;
    logic [3:0]      sync1_q;
    logic [3:0]      sync2_q;
    logic [3:0]      key_state_q;
    logic [3:0]      key_press_q;
    logic [3:0]      key_release_q;
    logic [3:0]      led_q;
    logic            busy_q;
    logic [CNTW-1:0] cnt_q;
    logic [1:0]      ptr_q;
    logic [1:0]      cur_id_q;
    logic            cur_lvl_q;

    logic [3:0]      pending;
    logic            pick_valid;
    logic [1:0]      pick_id;
    logic [1:0]      idx;

    // Round-robin pick: scan from the farthest offset back to ptr so the
    // closest pending key (starting at ptr) is the last one to win.
    always_comb begin
        pending    = sync2_q ^ key_state_q;
        pick_valid = 1'b0;
        pick_id    = ptr_q;
        idx        = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (pending[idx]) begin
                pick_valid = 1'b1;
                pick_id    = idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sync1_q       <= 4'b1111;
            sync2_q       <= 4'b1111;
            key_state_q   <= 4'b1111;
            key_press_q   <= 4'b0000;
            key_release_q <= 4'b0000;
            led_q         <= 4'b1111;
            busy_q        <= 1'b0;
            cnt_q         <= '0;
            ptr_q         <= 2'd0;
            cur_id_q      <= 2'd0;
            cur_lvl_q     <= 1'b1;
        end else begin
            sync1_q       <= keyin;
            sync2_q       <= sync1_q;
            key_press_q   <= 4'b0000;
            key_release_q <= 4'b0000;
            case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (pick_valid) begin
                        cur_id_q  <= pick_id;
                        cur_lvl_q <= sync2_q[pick_id];
                        state_q   <= FILTER;
                        busy_q    <= 1'b1;
                    end
                end
                FILTER: begin
                    // A bounce on the granted key forfeits its turn; the
                    // pointer moves past it so other keys get serviced first.
                    if (sync2_q[cur_id_q] != cur_lvl_q) begin
                        ptr_q   <= cur_id_q + 2'd1;
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_TERM) begin
                        cnt_q   <= '0;
                        state_q <= COMMIT;
                    end else begin
                        cnt_q <= cnt_q + CNTW'(1);
                    end
                end
                COMMIT: begin
                    key_state_q[cur_id_q] <= cur_lvl_q;
                    if (!cur_lvl_q) begin
                        key_press_q[cur_id_q] <= 1'b1;
                        led_q[cur_id_q]       <= ~led_q[cur_id_q];
                    end else begin
                        key_release_q[cur_id_q] <= 1'b1;
                    end
                    ptr_q   <= cur_id_q + 2'd1;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign key_state   = key_state_q;
    assign key_press   = key_press_q;
    assign key_release = key_release_q;
    assign led         = led_q;
    assign busy        = busy_q;
    assign grant_id    = cur_id_q;

endmodule

// File: tb/tb_key_debounce_sched.sv
// tb/tb_key_debounce_sched.sv - self-checking bench for key_debounce_sched

module tb_key_debounce_sched;

    localparam int CM = 3;

    logic       clk;
    logic       rst_n;
    logic [3:0] keyin;
    logic [3:0] key_state;
    logic [3:0] key_press;
    logic [3:0] key_release;
    logic [3:0] led;
    logic       busy;
    logic [1:0] grant_id;

    int n_tests = 0;
    int n_fail  = 0;

    key_debounce_sched #(.CNTW(20), .CNTMAX(CM)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .keyin      (keyin),
        .key_state  (key_state),
        .key_press  (key_press),
        .key_release(key_release),
        .led        (led),
        .busy       (busy),
        .grant_id   (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a grant is a start time; the key must hold its level
    // for CM+1 cycles after the grant and the event lands one cycle later.
    logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF, m_ks = 4'hF, m_led = 4'hF;
    logic [3:0] m_press = 4'h0, m_rel = 4'h0, m_pend;
    bit         m_busy = 1'b0;
    bit         m_glvl = 1'b1;
    int         m_gid = 0, m_ptr = 0;
    longint     m_edge = 0, m_gstart = 0, m_el;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = 4'hF; m_s2 = 4'hF; m_ks = 4'hF; m_led = 4'hF;
            m_press = 4'h0; m_rel = 4'h0;
            m_busy = 1'b0; m_gid = 0; m_ptr = 0; m_edge = 0;
        end else begin
            m_edge++;
            m_pend  = m_s2 ^ m_ks;
            m_press = 4'h0;
            m_rel   = 4'h0;
            if (!m_busy) begin
                for (int k = 3; k >= 0; k--)
                    if (m_pend[(m_ptr + k) % 4]) m_gid = (m_ptr + k) % 4;
                if (m_pend != 4'h0) begin
                    m_busy   = 1'b1;
                    m_glvl   = m_s2[m_gid];
                    m_gstart = m_edge;
                end
            end else begin
                m_el = m_edge - m_gstart;
                if (m_el <= CM + 1 && m_s2[m_gid] != m_glvl) begin
                    m_busy = 1'b0;
                    m_ptr  = (m_gid + 1) % 4;
                end else if (m_el == CM + 2) begin
                    m_ks[m_gid] = m_glvl;
                    if (!m_glvl) begin
                        m_press[m_gid] = 1'b1;
                        m_led[m_gid]   = ~m_led[m_gid];
                    end else begin
                        m_rel[m_gid] = 1'b1;
                    end
                    m_busy = 1'b0;
                    m_ptr  = (m_gid + 1) % 4;
                end
            end
            m_s2 = m_s1;
            m_s1 = keyin;
        end
    end

    // Pulse/grant recorder over a window of negedges (cycle index from 1).
    int         pc[$];
    logic [3:0] pv[$];
    int         rc[$];
    logic [3:0] rv[$];
    int         busy_cyc;
    logic [1:0] busy_gid;

    task automatic collect(input int n);
        pc.delete(); pv.delete(); rc.delete(); rv.delete();
        busy_cyc = 0;
        busy_gid = 2'd0;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (key_press != 4'h0)   begin pc.push_back(i); pv.push_back(key_press); end
            if (key_release != 4'h0) begin rc.push_back(i); rv.push_back(key_release); end
            if (busy && busy_cyc == 0) begin busy_cyc = i; busy_gid = grant_id; end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        keyin = 4'hF;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({key_state, led, key_press, key_release, busy, grant_id} !== {4'hF, 4'hF, 4'h0, 4'h0, 1'b0, 2'd0}) begin
            n_fail++;
            $display("FAIL reset_values got ks=%b led=%b pr=%b rl=%b busy=%b gid=%0d", key_state, led, key_press, key_release, busy, grant_id);
        end
        rst_n = 1'b1;
        collect(20);
        n_tests++;
        if (busy_cyc != 0 || pc.size() != 0 || rc.size() != 0 || led !== 4'hF) begin
            n_fail++;
            $display("FAIL idle_quiet got busy_cyc=%0d presses=%0d releases=%0d led=%b, need 0/0/0/1111", busy_cyc, pc.size(), rc.size(), led);
        end
    endtask

    task automatic test_press_release();
        do_reset();
        keyin = 4'b1101;
        collect(12);
        n_tests++;
        if (pc.size() != 1 || pc[0] != 8 || pv[0] !== 4'b0010) begin
            n_fail++;
            $display("FAIL press_key1 got n=%0d cyc=%0d val=%b, need n=1 cyc=8 val=0010", pc.size(), pc[0], pv[0]);
        end
        n_tests++;
        if (key_state !== 4'b1101 || led !== 4'b1101) begin
            n_fail++;
            $display("FAIL press_key1_state got ks=%b led=%b, need 1101/1101", key_state, led);
        end
        keyin = 4'b1111;
        collect(12);
        n_tests++;
        if (rc.size() != 1 || rc[0] != 8 || rv[0] !== 4'b0010 || pc.size() != 0) begin
            n_fail++;
            $display("FAIL release_key1 got n=%0d cyc=%0d val=%b presses=%0d, need n=1 cyc=8 val=0010 presses=0", rc.size(), rc[0], rv[0], pc.size());
        end
        n_tests++;
        if (key_state !== 4'b1111 || led !== 4'b1101) begin
            n_fail++;
            $display("FAIL release_key1_state got ks=%b led=%b, need 1111/1101", key_state, led);
        end
    endtask

    task automatic test_abort();
        do_reset();
        keyin = 4'b1011;
        collect(3);
        n_tests++;
        if (busy_cyc != 3 || busy_gid !== 2'd2) begin
            n_fail++;
            $display("FAIL abort_grant got busy_cyc=%0d gid=%0d, need 3/2", busy_cyc, busy_gid);
        end
        keyin = 4'b1111;
        collect(12);
        n_tests++;
        if (pc.size() != 0 || rc.size() != 0 || key_state !== 4'hF || led !== 4'hF || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_quiet got presses=%0d releases=%0d ks=%b led=%b busy=%b, need 0/0/1111/1111/0", pc.size(), rc.size(), key_state, led, busy);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        keyin = 4'b0110;
        collect(20);
        n_tests++;
        if (pc.size() != 2 || pc[0] != 8 || pv[0] !== 4'b0001 || pc[1] != 14 || pv[1] !== 4'b1000) begin
            n_fail++;
            $display("FAIL simul_order got n=%0d c0=%0d v0=%b c1=%0d v1=%b, need 2 8/0001 14/1000", pc.size(), pc[0], pv[0], pc[1], pv[1]);
        end
        n_tests++;
        if (led !== 4'b0110 || key_state !== 4'b0110) begin
            n_fail++;
            $display("FAIL simul_state got led=%b ks=%b, need 0110/0110", led, key_state);
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        keyin = 4'b1110;
        collect(12);
        keyin = 4'b1111;
        collect(12);
        n_tests++;
        if (rc.size() != 1 || rv[0] !== 4'b0001) begin
            n_fail++;
            $display("FAIL rr_setup got releases=%0d val=%b, need 1/0001", rc.size(), rv[0]);
        end
        keyin = 4'b1010;
        collect(20);
        n_tests++;
        if (busy_cyc != 3 || busy_gid !== 2'd2) begin
            n_fail++;
            $display("FAIL rr_first_grant got cyc=%0d gid=%0d, need 3/2", busy_cyc, busy_gid);
        end
        n_tests++;
        if (pc.size() != 2 || pc[0] != 8 || pv[0] !== 4'b0100 || pc[1] != 14 || pv[1] !== 4'b0001) begin
            n_fail++;
            $display("FAIL rr_order got n=%0d c0=%0d v0=%b c1=%0d v1=%b, need 2 8/0100 14/0001", pc.size(), pc[0], pv[0], pc[1], pv[1]);
        end
        n_tests++;
        if (led !== 4'b1011) begin
            n_fail++;
            $display("FAIL rr_led got %b, need 1011", led);
        end
    endtask

    task automatic test_reset_mid_filter();
        do_reset();
        keyin = 4'b0111;
        collect(4);
        n_tests++;
        if (busy !== 1'b1 || grant_id !== 2'd3) begin
            n_fail++;
            $display("FAIL midrst_pre got busy=%b gid=%0d, need 1/3", busy, grant_id);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({busy, key_state, led, key_press, key_release} !== {1'b0, 4'hF, 4'hF, 4'h0, 4'h0}) begin
            n_fail++;
            $display("FAIL midrst_async got busy=%b ks=%b led=%b pr=%b rl=%b", busy, key_state, led, key_press, key_release);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        collect(12);
        n_tests++;
        if (pc.size() != 1 || pc[0] != 8 || pv[0] !== 4'b1000) begin
            n_fail++;
            $display("FAIL midrst_refilter got n=%0d cyc=%0d val=%b, need 1/8/1000", pc.size(), pc[0], pv[0]);
        end
    endtask

    task automatic test_random();
        int shown = 0;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 5) == 0) keyin[$urandom_range(0, 3)] ^= 1'b1;
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
            @(negedge clk);
            n_tests++;
            if ({key_state, key_press, key_release, led, busy} !== {m_ks, m_press, m_rel, m_led, m_busy}
                || (m_busy && grant_id !== 2'(m_gid))) begin
                n_fail++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random cyc=%0d got ks=%b pr=%b rl=%b led=%b busy=%b gid=%0d need ks=%b pr=%b rl=%b led=%b busy=%b gid=%0d",
                             c, key_state, key_press, key_release, led, busy, grant_id, m_ks, m_press, m_rel, m_led, m_busy, m_gid);
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        keyin = 4'hF;
        test_reset();
        test_press_release();
        test_abort();
        test_simultaneous();
        test_round_robin();
        test_reset_mid_filter();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
